tx_info_sched: RTL and testbench

Round-robin scheduler that shares one `tx_info_phy` byte serializer among `NUM_REQ` info-frame requesters. It arbitrates requests, fetches payload bytes from the granted source and sequences the frame bytes into the phy via its `fire_tx`/`done_tx` handshake. Each frame is SYNC, header, payload and an optional checksum. It sits between the info sources and `tx_info_phy` in the syn_m_top transmit path.

---
 rtl/tx_info_sched.sv | 189 ++++++++++++++++++
 tb/tb_tx_info_sched.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_info_sched.sv
// Round-robin scheduler sharing one tx_info_phy serializer among NUM_REQ info-frame sources.
// Optional checksum byte: define TX_INFO_CKSUM_EN to include the CKS/W_CKS states and accumulator.
module tx_info_sched #(
    parameter int          NUM_REQ   = 4,
    parameter int          IFG       = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   len,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   byte_rd,
    output logic [3:0]             byte_idx,
    input  logic [7:0]             byte_data,
    output logic                   fire_tx,
    output logic [7:0]             data_tx,
    input  logic                   done_tx,
    output logic                   busy
);

    // Handshakes: fire_tx is a one-cycle start pulse to the phy, and done_tx is honoured only
    // in a W_* state. byte_rd is a one-cycle strobe, byte_data is taken the following cycle.
    typedef enum logic [3:0] {
        S_IDLE,
        S_ARB,
        S_SYNC,
        S_W_SYNC,
        S_HDR,
        S_W_HDR,
        S_RD,
        S_LAT,
        S_PAY,
        S_W_PAY,
`ifdef TX_INFO_CKSUM_EN
        S_CKS,
        S_W_CKS,
`endif
        S_GAP,
        S_ACK
    } state_t;

    state_t       state;
    state_t       state_nxt;
    state_t       st_after_pay;

    logic [1:0]   rr;
    logic [1:0]   src_id;
    logic [3:0]   cur_len;
    logic [3:0]   idx;
    logic [7:0]   pay_byte;
    logic [7:0]   gap_cnt;
    logic [7:0]   hdr;

    logic         arb_found;
    logic [1:0]   arb_win;
    logic [2:0]   arb_k;

    assign hdr = {src_id, 2'b00, cur_len};

`ifdef TX_INFO_CKSUM_EN
    logic [7:0]   acc;
    assign st_after_pay = S_CKS;
`else
    assign st_after_pay = S_GAP;
`endif

    // Round-robin search: first set request at or after rr, wrapping at NUM_REQ.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        arb_k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_k = 3'(rr) + 3'(i);
            if (arb_k >= 3'(NUM_REQ))
                arb_k = arb_k - 3'(NUM_REQ);
            if (!arb_found && req[arb_k[1:0]]) begin
                arb_found = 1'b1;
                arb_win   = arb_k[1:0];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (|req) state_nxt = S_ARB;
            S_ARB:    state_nxt = arb_found ? S_SYNC : S_IDLE;
            S_SYNC:   state_nxt = S_W_SYNC;
            S_W_SYNC: if (done_tx) state_nxt = S_HDR;
            S_HDR:    state_nxt = S_W_HDR;
            S_W_HDR:  if (done_tx) state_nxt = (cur_len != 4'd0) ? S_RD : st_after_pay;
            S_RD:     state_nxt = S_LAT;
            S_LAT:    state_nxt = S_PAY;
            S_PAY:    state_nxt = S_W_PAY;
            S_W_PAY: begin
                if (done_tx)
                    state_nxt = ({1'b0, idx} + 5'd1 < {1'b0, cur_len}) ? S_RD : st_after_pay;
            end
`ifdef TX_INFO_CKSUM_EN
            S_CKS:    state_nxt = S_W_CKS;
            S_W_CKS:  if (done_tx) state_nxt = S_GAP;
`endif
            S_GAP:    if (gap_cnt == 8'(IFG - 1)) state_nxt = S_ACK;
            S_ACK:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        byte_rd  = (state == S_RD);
        byte_idx = idx;
        ack      = grant & {NUM_REQ{state == S_ACK}};
        busy     = (state != S_IDLE);
    end

    // Frame context: captured once in ARB so later len changes cannot disturb the frame.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            grant    <= '0;
            rr       <= '0;
            src_id   <= '0;
            cur_len  <= '0;
            idx      <= '0;
            pay_byte <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                S_ARB: begin
                    if (arb_found) begin
                        grant          <= '0;
                        grant[arb_win] <= 1'b1;
                        src_id         <= arb_win;
                        cur_len        <= len[{arb_win, 2'b00} +: 4];
                        idx            <= '0;
                    end
                end
                S_LAT:   pay_byte <= byte_data;
                S_W_PAY: if (done_tx) idx <= idx + 4'd1;
                S_ACK: begin
                    grant <= '0;
                    rr    <= (src_id == 2'(NUM_REQ - 1)) ? 2'd0 : src_id + 2'd1;
                end
                default: ;
            endcase
            gap_cnt <= (state == S_GAP) ? gap_cnt + 8'd1 : 8'd0;
        end
    end

`ifdef TX_INFO_CKSUM_EN
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (state == S_HDR)
            acc <= hdr;
        else if (state == S_PAY)
            acc <= acc + pay_byte;
    end
`endif

    // Phy-facing byte is registered, so each fire lands the cycle after its issuing state.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            fire_tx <= 1'b0;
            data_tx <= '0;
        end else begin
            fire_tx <= 1'b0;
            data_tx <= '0;
            case (state)
                S_SYNC: begin fire_tx <= 1'b1; data_tx <= SYNC_BYTE; end
                S_HDR:  begin fire_tx <= 1'b1; data_tx <= hdr;       end
                S_PAY:  begin fire_tx <= 1'b1; data_tx <= pay_byte;  end
`ifdef TX_INFO_CKSUM_EN
                S_CKS:  begin fire_tx <= 1'b1; data_tx <= acc;       end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_info_sched.sv
// Directed bench for tx_info_sched: phy model answers done_tx 10 cycles after each fire_tx.
// Expected frames follow the TX_INFO_CKSUM_EN setting of the build.
module tb_tx_info_sched;

    localparam int NUM_REQ = 4;
    localparam int IFG     = 16;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic [3:0]  req     = '0;
    logic [15:0] len     = '0;
    logic [7:0]  byte_data = '0;
    logic        phy_done  = 1'b0;
    logic        spur_done = 1'b0;
    logic        done_tx;
    logic [3:0]  grant, ack, byte_idx;
    logic        byte_rd, fire_tx, busy;
    logic [7:0]  data_tx;

    assign done_tx = phy_done | spur_done;

    tx_info_sched #(.NUM_REQ(NUM_REQ), .IFG(IFG), .SYNC_BYTE(8'hA5)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .req(req), .len(len),
        .grant(grant), .ack(ack), .byte_rd(byte_rd), .byte_idx(byte_idx),
        .byte_data(byte_data), .fire_tx(fire_tx), .data_tx(data_tx),
        .done_tx(done_tx), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_tests = 0;
    int          n_fail  = 0;

    logic [7:0]  pay_mem [4][16];
    logic [7:0]  cap_q[$];
    logic [3:0]  gnt_q[$];
    time         fire_t_q[$];
    logic [3:0]  rd_idx_q[$];
    logic [3:0]  ack_q[$];
    time         ack_t  = 0;
    time         done_t = 0;
    int          phy_cnt = 0;
    logic [7:0]  exp_q[$];

    function automatic logic [1:0] gidx(input logic [3:0] g);
        gidx = g[1] ? 2'd1 : g[2] ? 2'd2 : g[3] ? 2'd3 : 2'd0;
    endfunction

    // Monitor and phy/source model, sampling 1 ns after each rising edge.
    initial begin
        forever begin
            @(posedge clk_sys);
            #1;
            if (fire_tx) begin
                cap_q.push_back(data_tx);
                gnt_q.push_back(grant);
                fire_t_q.push_back($time);
            end
            if (byte_rd) begin
                rd_idx_q.push_back(byte_idx);
                byte_data = pay_mem[gidx(grant)][byte_idx];
            end
            if (|ack) begin
                ack_q.push_back(ack);
                ack_t = $time;
            end
            phy_done = 1'b0;
            if (phy_cnt > 0) begin
                phy_cnt--;
                if (phy_cnt == 0) begin
                    phy_done = 1'b1;
                    done_t   = $time;
                end
            end
            if (fire_tx) phy_cnt = 10;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    task automatic wait_acks(input int n, input int budget, output bit ok);
        int got;
        got = 0;
        ok  = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk_sys);
            #2;
            if (|ack) begin
                req = req & ~ack;
                got++;
                if (got >= n) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        n_tests++;
        if ({grant, ack, byte_rd, byte_idx, fire_tx, data_tx, busy} !== 23'd0) begin
            $display("FAIL reset_outputs: got %h, want 0", {grant, ack, byte_rd, byte_idx, fire_tx, data_tx, busy});
            n_fail++;
        end
        rst_n = 1'b1;
        idle(3);
        n_tests++;
        if (busy !== 1'b0 || grant !== 4'd0) begin
            $display("FAIL reset_release_idle: busy=%b grant=%b, want 0/0000", busy, grant);
            n_fail++;
        end
    endtask

    task automatic test_single_frame();
        int b, ab, rb;
        time req_t;
        bit ok;
        int bad;
        pay_mem[1][0] = 8'h11;
        pay_mem[1][1] = 8'h22;
        len = 16'h0020;
        b = cap_q.size(); ab = ack_q.size(); rb = rd_idx_q.size();
        @(posedge clk_sys);
        #1;
        req   = 4'b0010;
        req_t = $time;
        wait_acks(1, 600, ok);
        idle(3);
        n_tests++;
        if (!ok) begin $display("FAIL single_timeout: no ack, want ack[1]"); n_fail++; end
        exp_q = '{8'hA5, 8'h42, 8'h11, 8'h22};
`ifdef TX_INFO_CKSUM_EN
        exp_q.push_back(8'h75);
`endif
        n_tests++;
        if (cap_q.size() - b != exp_q.size()) begin
            $display("FAIL single_count: got %0d bytes, want %0d", cap_q.size() - b, exp_q.size());
            n_fail++;
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (cap_q[b+i] !== exp_q[i]) begin
                    $display("FAIL single_byte%0d: got %h, want %h", i, cap_q[b+i], exp_q[i]);
                    n_fail++;
                end
            end
            bad = 0;
            for (int i = 0; i < exp_q.size(); i++) if (gnt_q[b+i] !== 4'b0010) bad++;
            n_tests++;
            if (bad != 0) begin $display("FAIL single_grant: %0d fires with grant != 0010", bad); n_fail++; end
            n_tests++;
            if ((fire_t_q[b] - req_t) != 64'd30) begin
                $display("FAIL single_latency: got %0t, want 30", fire_t_q[b] - req_t);
                n_fail++;
            end
        end
        n_tests++;
        if (ack_q.size() - ab != 1 || ack_q[ab] !== 4'b0010) begin
            $display("FAIL single_ack: got %0d acks first=%b, want 1 x 0010", ack_q.size() - ab, ack_q[ab]);
            n_fail++;
        end
        n_tests++;
        if ((ack_t - done_t) != 64'(10 * (IFG + 1))) begin
            $display("FAIL single_ack_delay: got %0t, want %0d", ack_t - done_t, 10 * (IFG + 1));
            n_fail++;
        end
        n_tests++;
        if (rd_idx_q.size() - rb != 2 || rd_idx_q[rb] !== 4'd0 || rd_idx_q[rb+1] !== 4'd1) begin
            $display("FAIL single_reads: got %0d reads, want idx 0,1", rd_idx_q.size() - rb);
            n_fail++;
        end
        n_tests++;
        if (grant !== 4'd0 || busy !== 1'b0) begin
            $display("FAIL single_after: grant=%b busy=%b, want 0000/0", grant, busy);
            n_fail++;
        end
    endtask

    task automatic test_zero_len();
        int b, rb, ab;
        bit ok;
        len = 16'h0000;
        b = cap_q.size(); rb = rd_idx_q.size(); ab = ack_q.size();
        req = 4'b0100;
        wait_acks(1, 600, ok);
        idle(3);
        exp_q = '{8'hA5, 8'h80};
`ifdef TX_INFO_CKSUM_EN
        exp_q.push_back(8'h80);
`endif
        n_tests++;
        if (!ok || cap_q.size() - b != exp_q.size()) begin
            $display("FAIL zero_count: ok=%0d got %0d bytes, want %0d", ok, cap_q.size() - b, exp_q.size());
            n_fail++;
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (cap_q[b+i] !== exp_q[i]) begin
                    $display("FAIL zero_byte%0d: got %h, want %h", i, cap_q[b+i], exp_q[i]);
                    n_fail++;
                end
            end
        end
        n_tests++;
        if (rd_idx_q.size() != rb) begin
            $display("FAIL zero_reads: got %0d byte_rd, want 0", rd_idx_q.size() - rb);
            n_fail++;
        end
        n_tests++;
        if (ack_q.size() - ab != 1 || ack_q[ab] !== 4'b0100) begin
            $display("FAIL zero_ack: got %0d acks, want 1 x 0100", ack_q.size() - ab);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int b, ab;
        bit ok;
        pay_mem[0][0] = 8'h01; pay_mem[0][1] = 8'h02; pay_mem[0][2] = 8'h03;
        len = 16'h0003;
        b = cap_q.size(); ab = ack_q.size();
        req = 4'b0001;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk_sys);
            #2;
            if (cap_q.size() - b >= 3) begin ok = 1'b1; break; end
        end
        n_tests++;
        if (!ok) begin $display("FAIL midrst_reach: payload fire not seen"); n_fail++; end
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        n_tests++;
        if ({grant, ack, byte_rd, byte_idx, fire_tx, data_tx, busy} !== 23'd0) begin
            $display("FAIL midrst_outputs: got %h, want 0", {grant, ack, byte_rd, byte_idx, fire_tx, data_tx, busy});
            n_fail++;
        end
        idle(12);
        n_tests++;
        if (ack_q.size() != ab || busy !== 1'b0) begin
            $display("FAIL midrst_noack: got %0d acks busy=%b, want 0/0", ack_q.size() - ab, busy);
            n_fail++;
        end
        rst_n = 1'b1;
        idle(2);
        pay_mem[1][0] = 8'h3C;
        len = 16'h0010;
        b = cap_q.size();
        req = 4'b1010;
        wait_acks(2, 1200, ok);
        idle(3);
        n_tests++;
        if (!ok || cap_q.size() - b < 2 || cap_q[b] !== 8'hA5 || cap_q[b+1] !== 8'h41) begin
            $display("FAIL midrst_restart: ok=%0d first bytes %h %h, want A5 41", ok, cap_q[b], cap_q[b+1]);
            n_fail++;
        end
        n_tests++;
        if (ack_q.size() - ab != 2 || ack_q[ab] !== 4'b0010 || ack_q[ab+1] !== 4'b1000) begin
            $display("FAIL midrst_order: got %0d acks first=%b, want 0010 then 1000", ack_q.size() - ab, ack_q[ab]);
            n_fail++;
        end
    endtask

    task automatic test_robustness();
        int b, ab, rb, bad;
        bit ok;
        idle(2);
        spur_done = 1'b1;
        idle(1);
        spur_done = 1'b0;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (busy !== 1'b0 || fire_tx !== 1'b0) bad++;
            idle(1);
        end
        n_tests++;
        if (bad != 0) begin $display("FAIL robust_spurious: %0d cycles left IDLE, want 0", bad); n_fail++; end
        pay_mem[0][0] = 8'h05; pay_mem[0][1] = 8'h06; pay_mem[0][2] = 8'h07;
        len = 16'h0003;
        b = cap_q.size(); ab = ack_q.size(); rb = rd_idx_q.size();
        req = 4'b0001;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk_sys);
            #2;
            if (rd_idx_q.size() > rb) begin ok = 1'b1; break; end
        end
        req = 4'b0000;
        len = 16'h000F;
        n_tests++;
        if (!ok) begin $display("FAIL robust_reach: no byte_rd seen"); n_fail++; end
        wait_acks(1, 800, ok);
        idle(4);
        exp_q = '{8'hA5, 8'h03, 8'h05, 8'h06, 8'h07};
`ifdef TX_INFO_CKSUM_EN
        exp_q.push_back(8'h15);
`endif
        n_tests++;
        if (!ok || cap_q.size() - b != exp_q.size()) begin
            $display("FAIL robust_count: ok=%0d got %0d bytes, want %0d", ok, cap_q.size() - b, exp_q.size());
            n_fail++;
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (cap_q[b+i] !== exp_q[i]) begin
                    $display("FAIL robust_byte%0d: got %h, want %h", i, cap_q[b+i], exp_q[i]);
                    n_fail++;
                end
            end
        end
        n_tests++;
        if (ack_q.size() - ab != 1 || busy !== 1'b0) begin
            $display("FAIL robust_ack: got %0d acks busy=%b, want 1/0", ack_q.size() - ab, busy);
            n_fail++;
        end
    endtask

    task automatic test_fairness();
        int b, ab, nb;
        bit ok;
        logic [3:0] exp_ack [4];
        logic [7:0] exp_hdr [4];
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        for (int k = 0; k < 4; k++) pay_mem[k][0] = 8'(8'h30 + k);
        len = 16'h1111;
`ifdef TX_INFO_CKSUM_EN
        nb = 4;
`else
        nb = 3;
`endif
        b = cap_q.size(); ab = ack_q.size();
        req = 4'b1111;
        wait_acks(4, 3000, ok);
        idle(3);
        exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_hdr = '{8'h01, 8'h41, 8'h81, 8'hC1};
        n_tests++;
        if (!ok || ack_q.size() - ab != 4 || cap_q.size() - b != 4 * nb) begin
            $display("FAIL fair_all_count: ok=%0d acks=%0d bytes=%0d, want 4/%0d", ok, ack_q.size() - ab, cap_q.size() - b, 4 * nb);
            n_fail++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (ack_q[ab+i] !== exp_ack[i] || cap_q[b+i*nb+1] !== exp_hdr[i]) begin
                    $display("FAIL fair_all_%0d: ack=%b hdr=%h, want %b %h", i, ack_q[ab+i], cap_q[b+i*nb+1], exp_ack[i], exp_hdr[i]);
                    n_fail++;
                end
            end
        end
        ab = ack_q.size();
        req = 4'b0101;
        wait_acks(2, 1500, ok);
        idle(3);
        n_tests++;
        if (!ok || ack_q.size() - ab != 2 || ack_q[ab] !== 4'b0001 || ack_q[ab+1] !== 4'b0100) begin
            $display("FAIL fair_0101: ok=%0d acks=%0d first=%b, want 0001 then 0100", ok, ack_q.size() - ab, ack_q[ab]);
            n_fail++;
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 16; j++)
                pay_mem[k][j] = '0;
        test_reset();
        test_single_frame();
        test_zero_len();
        test_reset_mid_frame();
        test_robustness();
        test_fairness();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
